// File: rtl/button_event_if.sv
// Button event bus: enable and debounced level in, registered one-cycle event pulses out.
// The pulses have no backpressure: each is valid for exactly one cycle and the consumer must sample it then.
interface button_event_if;
    logic       en;
    logic       level_n;
    logic       press_pulse;
    logic       short_pulse;
    logic       long_pulse;
    logic       repeat_pulse;
    logic       release_pulse;
    logic       held;
    logic [1:0] state_dbg;

    modport master (
        output en,
        output level_n,
        input  press_pulse,
        input  short_pulse,
        input  long_pulse,
        input  repeat_pulse,
        input  release_pulse,
        input  held,
        input  state_dbg
    );

    modport slave (
        input  en,
        input  level_n,
        output press_pulse,
        output short_pulse,
        output long_pulse,
        output repeat_pulse,
        output release_pulse,
        output held,
        output state_dbg
    );
endinterface

// File: rtl/button_event.sv
// Turns a debounced active-low button level into press / short / long / repeat / release pulses.
// All counts are in clock cycles (milliseconds on the 1 kHz tick).
module button_event #(
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200
) (
    input  logic          clk_1k,
    input  logic          rst_n,
    button_event_if.slave bus
);
    localparam logic [15:0] LONG_CNT = 16'(LONG_MS);
    localparam logic [15:0] REP_CNT  = 16'(REPEAT_MS);
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;
    localparam bit          REP_ON   = (REPEAT_MS != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_LONG  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic [15:0] rep_cnt_q, rep_cnt_d;
    logic        prev_n_q;

    logic        press_q, press_d;
    logic        short_q, short_d;
    logic        long_q, long_d;
    logic        repeat_q, repeat_d;
    logic        release_q, release_d;
    logic        held_q;

    logic        press_edge;
    logic        released;
    logic        long_due;
    logic        repeat_due;

    // prev_n resets low so a button held through reset must be re-pressed to register.
    assign press_edge = prev_n_q & ~bus.level_n;
    assign released   = bus.level_n;
    assign long_due   = (hold_cnt_q == LONG_CNT);
    assign repeat_due = REP_ON && (rep_cnt_q == REP_CNT);

    always_ff @(posedge clk_1k) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
            prev_n_q   <= 1'b0;
            press_q    <= 1'b0;
            short_q    <= 1'b0;
            long_q     <= 1'b0;
            repeat_q   <= 1'b0;
            release_q  <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            prev_n_q   <= bus.level_n;
            press_q    <= press_d;
            short_q    <= short_d;
            long_q     <= long_d;
            repeat_q   <= repeat_d;
            release_q  <= release_d;
            held_q     <= (state_d != ST_IDLE);
        end
    end

    always_comb begin : next_state
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        if (!bus.en) begin
            state_d    = ST_IDLE;
            hold_cnt_d = '0;
            rep_cnt_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (press_edge) begin
                        state_d    = ST_PRESS;
                        hold_cnt_d = 16'd1;
                    end
                end
                ST_PRESS: begin
                    // Release is tested first so a release on the threshold edge stays a click.
                    if (released) begin
                        state_d = ST_IDLE;
                    end else if (long_due) begin
                        state_d   = ST_LONG;
                        rep_cnt_d = 16'd1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 16'd1;
                    end
                end
                ST_LONG: begin
                    if (released) begin
                        state_d = ST_IDLE;
                    end else if (repeat_due) begin
                        rep_cnt_d = 16'd1;
                    end else if (rep_cnt_q != CNT_MAX) begin
                        rep_cnt_d = rep_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin : outputs
        press_d   = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        release_d = 1'b0;
        if (bus.en) begin
            unique case (state_q)
                ST_IDLE: begin
                    press_d = press_edge;
                end
                ST_PRESS: begin
                    short_d   = released;
                    release_d = released;
                    long_d    = ~released & long_due;
                end
                ST_LONG: begin
                    release_d = released;
                    repeat_d  = ~released & repeat_due;
                end
                default: begin
                    press_d = 1'b0;
                end
            endcase
        end
    end

    assign bus.press_pulse   = press_q;
    assign bus.short_pulse   = short_q;
    assign bus.long_pulse    = long_q;
    assign bus.repeat_pulse  = repeat_q;
    assign bus.release_pulse = release_q;
    assign bus.held          = held_q;
    assign bus.state_dbg     = state_q;
endmodule

// File: tb/tb_button_event.sv
// Bench for button_event: two instances (repeat on / repeat off) driven in lockstep and checked
// every cycle against a timestamp-based event model.
module tb_button_event;
  localparam int LONG_MS = 20;
  localparam int REP_A   = 5;
  localparam int REP_B   = 0;

  localparam int B_HELD = 0;
  localparam int B_REL  = 1;
  localparam int B_REP  = 2;
  localparam int B_LONG = 3;
  localparam int B_SHRT = 4;
  localparam int B_PRS  = 5;

  // clock / reset
  logic clk_1k = 1'b0;
  logic rst_n  = 1'b0;
  always #5 clk_1k = ~clk_1k;

  button_event_if bus_a ();
  button_event_if bus_b ();

  button_event #(.LONG_MS(LONG_MS), .REPEAT_MS(REP_A)) dut_a (
    .clk_1k(clk_1k),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  button_event #(.LONG_MS(LONG_MS), .REPEAT_MS(REP_B)) dut_b (
    .clk_1k(clk_1k),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  // scoreboard state
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  string names [6] = '{"held", "release", "repeat", "long", "short", "press"};

  // reference model: a tracked press is a start timestamp; events follow from its age
  int   rep_per [2];
  bit   m_trk   [2];
  int   m_t0    [2];
  bit   m_prev;
  logic [5:0] exp_q [$];

  int cnt_long [2];
  int cnt_rep  [2];

  int   r_run;
  logic r_lvl;
  logic r_en;
  logic r_rst;

  task automatic check(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_edge(input logic lvl, input logic e, input logic r);
    logic [5:0] ev;
    int age;
    for (int i = 0; i < 2; i++) begin
      ev = '0;
      if (!r || !e) begin
        m_trk[i] = 1'b0;
      end else if (!m_trk[i]) begin
        if (m_prev && !lvl) begin
          m_trk[i]  = 1'b1;
          m_t0[i]   = cyc;
          ev[B_PRS] = 1'b1;
        end
      end else begin
        age = cyc - m_t0[i];
        if (lvl) begin
          ev[B_REL]  = 1'b1;
          ev[B_SHRT] = (age <= LONG_MS);
          m_trk[i]   = 1'b0;
        end else if (age == LONG_MS) begin
          ev[B_LONG] = 1'b1;
        end else if (age > LONG_MS && rep_per[i] != 0 && ((age - LONG_MS) % rep_per[i]) == 0) begin
          ev[B_REP] = 1'b1;
        end
      end
      ev[B_HELD] = m_trk[i];
      exp_q.push_back(ev);
    end
    m_prev = r ? lvl : 1'b0;
  endtask

  // driver: apply inputs, take one edge, then compare both instances
  task automatic step(input logic lvl, input logic e, input logic r);
    logic [5:0] obs [2];
    logic [5:0] expv;
    bus_a.level_n = lvl;
    bus_b.level_n = lvl;
    bus_a.en      = e;
    bus_b.en      = e;
    rst_n         = r;
    @(posedge clk_1k);
    #1;
    cyc++;
    model_edge(lvl, e, r);
    obs[0] = {bus_a.press_pulse, bus_a.short_pulse, bus_a.long_pulse,
              bus_a.repeat_pulse, bus_a.release_pulse, bus_a.held};
    obs[1] = {bus_b.press_pulse, bus_b.short_pulse, bus_b.long_pulse,
              bus_b.repeat_pulse, bus_b.release_pulse, bus_b.held};
    for (int i = 0; i < 2; i++) begin
      expv = exp_q.pop_front();
      for (int k = 0; k < 6; k++) begin
        check($sformatf("%s_%s", (i == 0) ? "a" : "b", names[k]), obs[i][k], expv[k]);
      end
      if (obs[i][B_LONG]) cnt_long[i]++;
      if (obs[i][B_REP])  cnt_rep[i]++;
    end
  endtask

  task automatic run(input logic lvl, input int n);
    for (int k = 0; k < n; k++) step(lvl, 1'b1, 1'b1);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      cnt_long[i] = 0;
      cnt_rep[i]  = 0;
    end
  endtask

  initial begin
    rep_per[0] = REP_A;
    rep_per[1] = REP_B;
    m_trk[0] = 1'b0;
    m_trk[1] = 1'b0;
    m_t0[0]  = 0;
    m_t0[1]  = 0;
    m_prev   = 1'b0;
    clear_counts();
    bus_a.level_n = 1'b1;
    bus_b.level_n = 1'b1;
    bus_a.en = 1'b1;
    bus_b.en = 1'b1;

    // reset, then idle
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0);
    run(1'b1, 5);

    // short click: 3 cycles low
    run(1'b0, 3);
    run(1'b1, 5);

    // long hold of 32 cycles: long at 20, repeats at 25 and 30
    clear_counts();
    run(1'b0, 32);
    run(1'b1, 5);
    check_int("a_long_count_32", cnt_long[0], 1);
    check_int("a_repeat_count_32", cnt_rep[0], 2);

    // threshold boundary: release at n+20 stays short, release at n+21 is long
    run(1'b0, 20);
    run(1'b1, 4);
    run(1'b0, 21);
    run(1'b1, 4);

    // 100-cycle hold: instance b has repeat disabled
    clear_counts();
    run(1'b0, 100);
    run(1'b1, 4);
    check_int("b_long_count_100", cnt_long[1], 1);
    check_int("b_repeat_count_100", cnt_rep[1], 0);
    check_int("a_long_count_100", cnt_long[0], 1);
    check_int("a_repeat_count_100", cnt_rep[0], 15);

    // button held through reset, released, re-pressed
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0);
    run(1'b0, 5);
    run(1'b1, 3);
    run(1'b0, 4);
    run(1'b1, 4);

    // en dropped mid-press, raised while still held, then normal click
    run(1'b0, 5);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b1);
    run(1'b0, 30);
    run(1'b1, 3);
    run(1'b0, 1);
    run(1'b1, 4);

    // randomized level runs with occasional enable drops and resets
    r_lvl = 1'b1;
    for (int s = 0; s < 80; s++) begin
      r_lvl = ~r_lvl;
      if (r_lvl == 1'b0 && $urandom_range(0, 2) == 0) r_run = $urandom_range(15, 45);
      else r_run = $urandom_range(1, 8);
      for (int k = 0; k < r_run; k++) begin
        r_en  = ($urandom_range(0, 30) != 0);
        r_rst = ($urandom_range(0, 150) != 0);
        step(r_lvl, r_en, r_rst);
      end
    end
    run(1'b1, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
